// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one SDRAM controller port between the CPU bus bridge (port 0) and
// the JTAG debug/memory-load bridge (port 1). Round-robin, one single-word
// transaction per grant, with a watchdog that ends a hung access with an error.

module sdram_port_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    // port 0: CPU bridge
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    output logic          cpu_err_o,
    output logic [DW-1:0] cpu_rdata_o,
    // port 1: JTAG bridge
    input  logic          jtag_req_i,
    input  logic          jtag_we_i,
    input  logic [AW-1:0] jtag_addr_i,
    input  logic [DW-1:0] jtag_wdata_i,
    output logic          jtag_ack_o,
    output logic          jtag_err_o,
    output logic [DW-1:0] jtag_rdata_o,
    // downstream SDRAM controller
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    // status
    output logic [1:0]    grant_o,
    output logic          timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Watchdog value seen during the TIMEOUT-th BUSY cycle (counter cleared on entry).
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          last_q;        // port served most recently (1 = JTAG)
    logic [15:0]   wdog_q;
    logic [1:0]    grant_q;
    logic          mem_req_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          cpu_ack_q, cpu_err_q, jtag_ack_q, jtag_err_q;
    logic [DW-1:0] cpu_rdata_q, jtag_rdata_q;
    logic          timeout_q;

    // Decoded control from the FSM
    logic start;      // grant issued this cycle
    logic sel_jtag;   // which port the grant goes to
    logic fin_ack;    // downstream acknowledged
    logic fin_to;     // watchdog expired without ack

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and arbitration decision; an ack on the expiry cycle wins over the watchdog
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        sel_jtag = 1'b0;
        fin_ack  = 1'b0;
        fin_to   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i || jtag_req_i) begin
                    start    = 1'b1;
                    sel_jtag = (cpu_req_i && jtag_req_i) ? ~last_q : jtag_req_i;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ack_i) begin
                    fin_ack = 1'b1;
                    state_d = S_DONE;
                end else if (wdog_q == WD_LAST) begin
                    fin_to  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the winning request and hold the downstream handshake until completion
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
        end else if (start) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= sel_jtag ? jtag_we_i    : cpu_we_i;
            mem_addr_q  <= sel_jtag ? jtag_addr_i  : cpu_addr_i;
            mem_wdata_q <= sel_jtag ? jtag_wdata_i : cpu_wdata_i;
            grant_q     <= sel_jtag ? 2'b10 : 2'b01;
            last_q      <= sel_jtag;
        end else if (fin_ack || fin_to) begin
            mem_req_q   <= 1'b0;
            grant_q     <= 2'b00;
        end
    end

    // Watchdog: cleared on grant, counts every BUSY cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  wdog_q <= '0;
        else if (start)             wdog_q <= '0;
        else if (state_q == S_BUSY) wdog_q <= wdog_q + 16'd1;
    end

    // Completion pulses to the granted port; read data held between acks
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            jtag_ack_q   <= 1'b0;
            jtag_err_q   <= 1'b0;
            jtag_rdata_q <= '0;
        end else begin
            cpu_ack_q  <= 1'b0;
            cpu_err_q  <= 1'b0;
            jtag_ack_q <= 1'b0;
            jtag_err_q <= 1'b0;
            if (fin_ack || fin_to) begin
                if (grant_q[0]) begin
                    cpu_ack_q   <= 1'b1;
                    cpu_err_q   <= fin_to;
                    cpu_rdata_q <= fin_to ? '0 : mem_rdata_i;
                end
                if (grant_q[1]) begin
                    jtag_ack_q   <= 1'b1;
                    jtag_err_q   <= fin_to;
                    jtag_rdata_q <= fin_to ? '0 : mem_rdata_i;
                end
            end
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       timeout_q <= 1'b0;
        else if (fin_to) timeout_q <= 1'b1;
    end

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign grant_o      = grant_q;
    assign timeout_o    = timeout_q;
    assign cpu_ack_o    = cpu_ack_q;
    assign cpu_err_o    = cpu_err_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign jtag_ack_o   = jtag_ack_q;
    assign jtag_err_o   = jtag_err_q;
    assign jtag_rdata_o = jtag_rdata_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-port arbiter sharing the single SDRAM controller port between the NEORV32 CPU bus bridge (port 0) and the JTAG debug/memory-load bridge (port 1).
- Round-robin grant, one single-word transaction per grant.
- Latches request fields and sequences the downstream request/ack handshake.
- Watchdog terminates a hung transaction with an error response.
- Sits between the CPU/JTAG bridges and the SDRAM controller inside the top level.

Parameters:
- AW, 24, address width (SDRAM word address).
- DW, 16, data width (SDRAM word).
- TIMEOUT, 255, maximum BUSY cycles without mem_ack_i before error termination (1..65535).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- cpu_req_i  in  1  port 0 request; hold until cpu_ack_o.
- cpu_we_i  in  1  port 0 write enable (1 = write, 0 = read).
- cpu_addr_i  in  AW  port 0 address.
- cpu_wdata_i  in  DW  port 0 write data.
- cpu_ack_o  out  1  port 0 completion pulse (1 cycle).
- cpu_err_o  out  1  port 0 timeout error; valid with cpu_ack_o.
- cpu_rdata_o  out  DW  port 0 read data; valid with cpu_ack_o.
- jtag_req_i, jtag_we_i, jtag_addr_i, jtag_wdata_i, jtag_ack_o, jtag_err_o, jtag_rdata_o  as port 0, for port 1.
- mem_req_o  out  1  downstream request; held until mem_ack_i.
- mem_we_o  out  1  downstream write enable.
- mem_addr_o  out  AW  downstream address.
- mem_wdata_o  out  DW  downstream write data.
- mem_ack_i  in  1  downstream completion pulse.
- mem_rdata_i  in  DW  downstream read data; valid with mem_ack_i.
- grant_o  out  2  one-hot owner; nonzero only in BUSY.
- timeout_o  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset: all outputs 0, state IDLE, last-served pointer = 1 (port 0 wins the first contention).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port not last served; update the pointer on every grant.
  - On grant: register we/addr/wdata into the mem_* outputs, set grant_o, go to BUSY. mem_req_o rises the cycle after the req is first seen in IDLE.
- BUSY:
  - mem_req_o = 1 and mem_* outputs stay stable until mem_ack_i.
  - Watchdog counter clears on entry and increments each BUSY cycle.
  - mem_ack_i = 1: the granted port's ack_o pulses high next cycle with rdata_o = mem_rdata_i (registered) and err_o = 0. mem_req_o and grant_o drop next cycle. Go to DONE.
  - Counter reaches TIMEOUT with no ack: granted ack_o and err_o pulse next cycle, rdata_o = 0, timeout_o set, mem_req_o dropped. Go to DONE.
  - mem_ack_i on the same cycle the counter hits TIMEOUT: treat as a normal ack, no error.
- DONE: one turnaround cycle so the requester can drop or re-present req; then IDLE.
- Latency: req seen at cycle 0; mem_ack_i at cycle k ≥ 1 gives ack_o at cycle k+1; next grant no earlier than cycle k+3.
- Requester dropping req during BUSY does not abort: the transaction completes and ack_o still pulses.
- Requester-side changes to addr/we/wdata during BUSY are ignored (fields were latched).
- mem_ack_i outside BUSY is ignored.
- Non-granted port's ack_o/err_o stay 0.
- rdata_o holds its last value between acks.
- Write acks return rdata_o = mem_rdata_i, treated as don't-care.
- Reset asserted mid-BUSY: immediate return to reset values; the pending transaction is lost; no ack is issued.
- Back-to-back: a port holding req continuously alternates with the other port when both are active. A single active port gets every slot.

Test Plan:
- Reset, cpu read addr 0x000123, mem_ack_i 3 cycles after mem_req_o with rdata 0xBEEF -> mem_addr_o = 0x000123, mem_we_o = 0, cpu_ack_o one pulse with 0xBEEF, jtag_ack_o never, grant_o = 01 during BUSY.
- cpu and jtag both request from reset, continuous, mem_ack_i always 1 cycle after mem_req_o -> grant order cpu, jtag, cpu, jtag; each ack 1 cycle after mem_ack_i; 4 cycles between grants.
- jtag write 0x00ABCD ← 0x1234, mem_ack_i never asserted, TIMEOUT = 255 -> after 255 BUSY cycles jtag_ack_o = 1 with jtag_err_o = 1 and jtag_rdata_o = 0; timeout_o = 1 and stays 1; a following cpu transaction completes normally with err = 0.
- cpu request, then cpu_req_i dropped and cpu_addr_i changed while BUSY -> mem_addr_o keeps its original value; cpu_ack_o still pulses after mem_ack_i.
- rst_i pulsed during BUSY, then late mem_ack_i -> mem_req_o = 0 and grant_o = 0 immediately; late ack produces no cpu/jtag ack; next contention grants cpu first.
- Spurious mem_ack_i in IDLE and mem_ack_i coincident with the TIMEOUT cycle -> first ignored; second completes with err = 0 and timeout_o unchanged.
